video_timing_decoder: RTL

Receive-side counterpart of the raster timing generator. Samples an incoming hs/vs/de stream and recovers per-pixel x/y coordinates. Measures line and frame totals, checks them against the expected mode, and declares lock after a run of conforming frames. Used for loopback checking of the generator and as the front end of any capture path fed by external RGB video.

---
 rtl/video_timing_pkg.sv | 25 ++
 rtl/video_timing_decoder_sync_edge_detector.sv | 31 +++
 rtl/video_timing_decoder.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/video_timing_pkg.sv
// Raster timing for 640x480@60, shared by the timing generator and the decoder,
// plus the lock state encoding used by the decoder.
package video_timing_pkg;

  localparam int H_ACTIVE      = 640;
  localparam int H_FRONT_PORCH = 16;
  localparam int H_SYNC        = 96;
  localparam int H_BACK_PORCH  = 48;
  localparam int H_TOTAL       = H_ACTIVE + H_FRONT_PORCH + H_SYNC + H_BACK_PORCH;
  localparam bit H_SYNC_POL    = 1'b0;

  localparam int V_ACTIVE      = 480;
  localparam int V_FRONT_PORCH = 10;
  localparam int V_SYNC        = 2;
  localparam int V_BACK_PORCH  = 33;
  localparam int V_TOTAL       = V_ACTIVE + V_FRONT_PORCH + V_SYNC + V_BACK_PORCH;
  localparam bit V_SYNC_POL    = 1'b0;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } lock_state_t;

endpackage

// File: rtl/video_timing_decoder_sync_edge_detector.sv
// Registers one sync input, compares it against the sync polarity and emits a
// one-ce pulse on the leading edge of the active level.
module sync_edge_detector #(
  parameter bit POLARITY = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ce,
  input  logic level,
  output logic lead
);

  logic level_q;
  logic active;
  logic active_prev;

  // Level register resets to the inactive level so no edge appears after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q     <= ~POLARITY;
      active_prev <= 1'b0;
    end else if (ce) begin
      level_q     <= level;
      active_prev <= active;
    end
  end

  assign active = (level_q == POLARITY);
  assign lead   = active & ~active_prev;

endmodule

// File: rtl/video_timing_decoder.sv
// Recovers pixel coordinates from an hs/vs/de stream, measures line and frame
// totals and declares lock after LOCK_FRAMES consecutive conforming frames.
module video_timing_decoder
  import video_timing_pkg::*;
#(
  parameter int HOR_TOTAL_PIXELS  = H_TOTAL,
  parameter int HOR_ACTIVE_PIXELS = H_ACTIVE,
  parameter bit HOR_SYNC_POLARITY = H_SYNC_POL,
  parameter int VER_TOTAL_PIXELS  = V_TOTAL,
  parameter int VER_ACTIVE_PIXELS = V_ACTIVE,
  parameter bit VER_SYNC_POLARITY = V_SYNC_POL,
  parameter int LOCK_FRAMES       = 2
) (
  input  logic                                  clk_rgb,
  input  logic                                  rst_n,
  input  logic                                  ce,
  input  logic                                  hs,
  input  logic                                  vs,
  input  logic                                  de,
  output logic [$clog2(HOR_ACTIVE_PIXELS)-1:0]  x,
  output logic [$clog2(VER_ACTIVE_PIXELS)-1:0]  y,
  output logic                                  de_out,
  output logic                                  frame_start,
  output logic                                  locked,
  output logic                                  sync_error,
  output logic [$clog2(HOR_TOTAL_PIXELS):0]     h_total_meas,
  output logic [$clog2(VER_TOTAL_PIXELS):0]     v_total_meas
);

  localparam int XW = $clog2(HOR_ACTIVE_PIXELS);
  localparam int YW = $clog2(VER_ACTIVE_PIXELS);
  localparam int HW = $clog2(HOR_TOTAL_PIXELS) + 1;
  localparam int VW = $clog2(VER_TOTAL_PIXELS) + 1;
  localparam int GW = $clog2(LOCK_FRAMES + 1);

  localparam logic [HW-1:0] H_MAX  = '1;
  localparam logic [HW-1:0] H_EXP  = HW'(HOR_TOTAL_PIXELS);
  localparam logic [VW-1:0] V_MAX  = '1;
  localparam logic [VW-1:0] V_EXP  = VW'(VER_TOTAL_PIXELS);
  localparam logic [XW:0]   X_MAX  = '1;
  localparam logic [XW:0]   X_EXP  = (XW+1)'(HOR_ACTIVE_PIXELS);
  localparam logic [XW:0]   X_LAST = (XW+1)'(HOR_ACTIVE_PIXELS - 1);
  localparam logic [YW:0]   Y_MAX  = '1;
  localparam logic [YW:0]   Y_EXP  = (YW+1)'(VER_ACTIVE_PIXELS);
  localparam logic [YW:0]   Y_LAST = (YW+1)'(VER_ACTIVE_PIXELS - 1);
  localparam logic [GW-1:0] G_LOCK = GW'(LOCK_FRAMES);

  logic          hs_lead, vs_lead;
  logic          de_q, de_prev, de_fall;
  logic [HW-1:0] h_cnt, h_len;
  logic [VW-1:0] v_cnt;
  logic [XW:0]   x_cnt;
  logic [YW:0]   y_cnt;
  logic          bad_flag, line_bad, frame_bad, timeout;
  lock_state_t   state;
  logic [GW-1:0] good_cnt;

  sync_edge_detector #(.POLARITY(HOR_SYNC_POLARITY)) u_hs_edge (
    .clk(clk_rgb), .rst_n(rst_n), .ce(ce), .level(hs), .lead(hs_lead)
  );

  sync_edge_detector #(.POLARITY(VER_SYNC_POLARITY)) u_vs_edge (
    .clk(clk_rgb), .rst_n(rst_n), .ce(ce), .level(vs), .lead(vs_lead)
  );

  assign de_fall   = de_prev & ~de_q;
  assign h_len     = h_cnt + 1'b1;
  assign line_bad  = (hs_lead && (h_len != H_EXP)) || (de_fall && (x_cnt != X_EXP));
  // A line that closes on the same cycle as vs still belongs to the old frame.
  assign frame_bad = bad_flag || line_bad || (v_cnt != V_EXP) || (y_cnt != Y_EXP);
  assign timeout   = (h_cnt == H_MAX) && !hs_lead;

  always_ff @(posedge clk_rgb or negedge rst_n) begin
    if (!rst_n) begin
      de_q         <= 1'b0;
      de_prev      <= 1'b0;
      de_out       <= 1'b0;
      frame_start  <= 1'b0;
      x            <= '0;
      y            <= '0;
      h_cnt        <= '0;
      v_cnt        <= '0;
      x_cnt        <= '0;
      y_cnt        <= '0;
      h_total_meas <= '0;
      v_total_meas <= '0;
      bad_flag     <= 1'b0;
    end else if (ce) begin
      de_q        <= de;
      de_prev     <= de_q;
      de_out      <= de_q;
      frame_start <= vs_lead;
      x           <= XW'((x_cnt > X_LAST) ? X_LAST : x_cnt);
      y           <= YW'((y_cnt > Y_LAST) ? Y_LAST : y_cnt);

      if (hs_lead) begin
        h_total_meas <= h_len;
        h_cnt        <= '0;
      end else if (h_cnt != H_MAX) begin
        h_cnt <= h_len;
      end

      if (vs_lead) begin
        v_total_meas <= v_cnt;
        v_cnt        <= {{(VW-1){1'b0}}, hs_lead};
      end else if (hs_lead && (v_cnt != V_MAX)) begin
        v_cnt <= v_cnt + 1'b1;
      end

      if (!de_q)              x_cnt <= '0;
      else if (x_cnt != X_MAX) x_cnt <= x_cnt + 1'b1;

      if (vs_lead)                            y_cnt <= '0;
      else if (de_fall && (y_cnt != Y_MAX))   y_cnt <= y_cnt + 1'b1;

      if (vs_lead)       bad_flag <= 1'b0;
      else if (line_bad) bad_flag <= 1'b1;
    end
  end

  // state  | meaning
  // SEARCH | no frame reference yet; first vs edge starts a measured frame
  // CHECK  | counting consecutive good frames toward lock
  // LOCKED | timing conforms; a bad frame drops back to CHECK
  always_ff @(posedge clk_rgb or negedge rst_n) begin
    if (!rst_n) begin
      state      <= SEARCH;
      good_cnt   <= '0;
      locked     <= 1'b0;
      sync_error <= 1'b0;
    end else if (ce) begin
      sync_error <= 1'b0;
      if (timeout) begin
        state    <= SEARCH;
        good_cnt <= '0;
        locked   <= 1'b0;
      end else if (vs_lead) begin
        unique case (state)
          SEARCH: begin
            state    <= CHECK;
            good_cnt <= '0;
          end
          CHECK: begin
            if (frame_bad) begin
              good_cnt   <= '0;
              sync_error <= 1'b1;
            end else if ((good_cnt + 1'b1) == G_LOCK) begin
              state    <= LOCKED;
              good_cnt <= G_LOCK;
              locked   <= 1'b1;
            end else begin
              good_cnt <= good_cnt + 1'b1;
            end
          end
          LOCKED: begin
            if (frame_bad) begin
              state      <= CHECK;
              good_cnt   <= '0;
              locked     <= 1'b0;
              sync_error <= 1'b1;
            end
          end
          default: begin
            state    <= SEARCH;
            good_cnt <= '0;
            locked   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
